// File: rtl/timer_count_unit.sv
// Main counter stage of Timer_1: up/down auto-reload counter with one-pulse
// mode, software update trigger, ARR/PSC/CCR preload-shadow pairs, compare
// output and sticky update/compare flags. Advances only on the prescaler tick.
module timer_count_unit #(
    parameter int CW    = 16,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run_set,
    input  logic             run_clr,
    input  logic             dir,
    input  logic             opm,
    input  logic             arpe,
    input  logic             ug,
    input  logic             arr_wr,
    input  logic [CW-1:0]    arr_wdata,
    input  logic             psc_wr,
    input  logic [PSC_W-1:0] psc_wdata,
    input  logic             ccr_wr,
    input  logic [CW-1:0]    ccr_wdata,
    input  logic             cnt_wr,
    input  logic [CW-1:0]    cnt_wdata,
    input  logic             uif_clr,
    input  logic             ccif_clr,
    output logic [CW-1:0]    cnt,
    output logic [CW-1:0]    arr_sh,
    output logic [PSC_W-1:0] psc_sh,
    output logic             run,
    output logic             uev,
    output logic             uif,
    output logic             ccif,
    output logic             oc
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_arr_pre;
    logic [CW-1:0]    r_arr_sh;
    logic [PSC_W-1:0] r_psc_pre;
    logic [PSC_W-1:0] r_psc_sh;
    logic [CW-1:0]    r_ccr_pre;
    logic [CW-1:0]    r_ccr_sh;
    logic             r_run;
    logic             r_uev;
    logic             r_uif;
    logic             r_ccif;
    logic             r_oc;

    logic             w_step;
    logic             w_wrap_evt;
    logic             w_uev;
    logic             w_run_next;
    logic             w_ccif_set;
    logic [CW-1:0]    w_cnt_next;
    logic [CW-1:0]    w_arr_sh_next;
    logic [CW-1:0]    w_ccr_sh_next;
    logic [PSC_W-1:0] w_psc_sh_next;

    // Next-state evaluation: ug beats cnt_wr beats a tick-driven step.
    // Shadow loads use the preload values held before this edge, so a
    // preload write in the same cycle only shows up at the following UEV.
    always_comb begin
        w_step        = r_run && tick && !ug && !cnt_wr;
        w_wrap_evt    = 1'b0;
        w_cnt_next    = r_cnt;
        if (ug) begin
            w_cnt_next = dir ? r_arr_pre : '0;
        end else if (cnt_wr) begin
            w_cnt_next = cnt_wdata;
        end else if (w_step) begin
            if (!dir) begin
                if (r_cnt == r_arr_sh) begin
                    w_cnt_next = '0;
                    w_wrap_evt = 1'b1;
                end else begin
                    // Above-ARR values run on to all-ones and wrap silently.
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end else begin
                if (r_cnt == '0) begin
                    // Reload from the period that just ended.
                    w_cnt_next = r_arr_sh;
                    w_wrap_evt = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
        end

        w_uev = ug || w_wrap_evt;

        w_arr_sh_next = r_arr_sh;
        if (w_uev) begin
            w_arr_sh_next = r_arr_pre;
        end else if (arr_wr && !arpe) begin
            w_arr_sh_next = arr_wdata;
        end
        w_psc_sh_next = w_uev ? r_psc_pre : r_psc_sh;
        w_ccr_sh_next = w_uev ? r_ccr_pre : r_ccr_sh;

        // An OPM stop behaves exactly like run_clr; clearing beats setting.
        w_run_next = r_run;
        if (run_clr || (opm && w_wrap_evt)) begin
            w_run_next = 1'b0;
        end else if (run_set) begin
            w_run_next = 1'b1;
        end

        w_ccif_set = (w_step || ug) && (w_cnt_next == w_ccr_sh_next);
    end

    // Preload registers capture bus writes on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arr_pre <= '1;
            r_psc_pre <= '0;
            r_ccr_pre <= '0;
        end else begin
            if (arr_wr) r_arr_pre <= arr_wdata;
            if (psc_wr) r_psc_pre <= psc_wdata;
            if (ccr_wr) r_ccr_pre <= ccr_wdata;
        end
    end

    // Counter, shadow registers, run state and compare output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_arr_sh <= '1;
            r_psc_sh <= '0;
            r_ccr_sh <= '0;
            r_run    <= 1'b0;
            r_uev    <= 1'b0;
            r_oc     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_arr_sh <= w_arr_sh_next;
            r_psc_sh <= w_psc_sh_next;
            r_ccr_sh <= w_ccr_sh_next;
            r_run    <= w_run_next;
            r_uev    <= w_uev;
            r_oc     <= (w_cnt_next < w_ccr_sh_next);
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uif  <= 1'b0;
            r_ccif <= 1'b0;
        end else begin
            if (w_uev)        r_uif <= 1'b1;
            else if (uif_clr) r_uif <= 1'b0;
            if (w_ccif_set)    r_ccif <= 1'b1;
            else if (ccif_clr) r_ccif <= 1'b0;
        end
    end

    assign cnt    = r_cnt;
    assign arr_sh = r_arr_sh;
    assign psc_sh = r_psc_sh;
    assign run    = r_run;
    assign uev    = r_uev;
    assign uif    = r_uif;
    assign ccif   = r_ccif;
    assign oc     = r_oc;

endmodule
